// File: rtl/regfile_add_engine_pkg.sv
// Shared definitions for regfile_add_engine: engine FSM encoding, default sizes
// and the signed-overflow helper used by the adder stage.
package regfile_add_engine_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int AW_DEFAULT = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // Two's-complement overflow: operands agree in sign and the sum does not.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/regfile_core.sv
// Register storage with three host/display read ports, two engine read ports and
// one prioritised write port. Build option ZERO_REG_EN hardwires register 0 to zero.
module regfile_core
  import regfile_add_engine_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          host_wen,
  input  logic [AW-1:0] host_waddr,
  input  logic [DW-1:0] host_wdata,
  input  logic          eng_wen,
  input  logic [AW-1:0] eng_waddr,
  input  logic [DW-1:0] eng_wdata,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata2,
  input  logic [AW-1:0] test_addr,
  output logic [DW-1:0] test_data,
  input  logic [AW-1:0] eng_raddr_a,
  output logic [DW-1:0] eng_rdata_a,
  input  logic [AW-1:0] eng_raddr_b,
  output logic [DW-1:0] eng_rdata_b,
  output logic          wr_conflict
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];
  logic          eng_we;
  logic          host_we;

`ifdef ZERO_REG_EN
  assign eng_we  = eng_wen && (eng_waddr != '0);
  assign host_we = host_wen && !eng_wen && (host_waddr != '0);

  function automatic logic [DW-1:0] rd_port(input logic [AW-1:0] a);
    return (a == '0) ? '0 : mem[a];
  endfunction
`else
  assign eng_we  = eng_wen;
  assign host_we = host_wen && !eng_wen;

  function automatic logic [DW-1:0] rd_port(input logic [AW-1:0] a);
    return mem[a];
  endfunction
`endif

  assign rdata1      = rd_port(raddr1);
  assign rdata2      = rd_port(raddr2);
  assign test_data   = rd_port(test_addr);
  assign eng_rdata_a = rd_port(eng_raddr_a);
  assign eng_rdata_b = rd_port(eng_raddr_b);

  // The engine owns the write port on its writeback edge; any host write then is lost.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_conflict <= 1'b0;
    end else begin
      wr_conflict <= eng_wen && host_wen;
      if (eng_we) mem[eng_waddr] <= eng_wdata;
      else if (host_we) mem[host_waddr] <= host_wdata;
    end
  end

endmodule

// File: rtl/regfile_add_engine.sv
// Register file with a read-add-writeback engine (rd <= rs1 + rs2 + cin).
// Build option ZERO_REG_EN makes register 0 read as zero and discard writes.
module regfile_add_engine
  import regfile_add_engine_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata2,
  input  logic [AW-1:0] test_addr,
  output logic [DW-1:0] test_data,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [AW-1:0] op_rs1,
  input  logic [AW-1:0] op_rs2,
  input  logic [AW-1:0] op_rd,
  input  logic          op_cin,
  output logic          done_valid,
  output logic [DW-1:0] done_result,
  output logic          done_cout,
  output logic          done_ovf,
  output logic          wr_conflict
);

  // state   | meaning
  // IDLE    | op_ready high, waiting for a command
  // READ    | operands sampled from rs1/rs2 at the exit edge
  // EXEC    | sum, carry and overflow registered at the exit edge
  // WB      | sum written to rd and done_* updated at the exit edge

  state_t        state;
  logic [AW-1:0] rs1_q, rs2_q, rd_q;
  logic          cin_q;
  logic [DW-1:0] opa, opb, sum_q;
  logic          cout_q, ovf_q;
  logic [DW-1:0] eng_rdata_a, eng_rdata_b;
  logic [DW:0]   sum_full;
  logic          eng_wen;

  assign sum_full = {1'b0, opa} + {1'b0, opb} + {{DW{1'b0}}, cin_q};
  assign eng_wen  = (state == ST_WB);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      op_ready    <= 1'b1;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      cin_q       <= 1'b0;
      opa         <= '0;
      opb         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      done_valid  <= 1'b0;
      done_result <= '0;
      done_cout   <= 1'b0;
      done_ovf    <= 1'b0;
    end else begin
      done_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (op_valid) begin
            rs1_q    <= op_rs1;
            rs2_q    <= op_rs2;
            rd_q     <= op_rd;
            cin_q    <= op_cin;
            op_ready <= 1'b0;
            state    <= ST_READ;
          end
        end
        ST_READ: begin
          opa   <= eng_rdata_a;
          opb   <= eng_rdata_b;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          {cout_q, sum_q} <= sum_full;
          ovf_q           <= add_ovf(opa[DW-1], opb[DW-1], sum_full[DW-1]);
          state           <= ST_WB;
        end
        ST_WB: begin
          done_valid  <= 1'b1;
          done_result <= sum_q;
          done_cout   <= cout_q;
          done_ovf    <= ovf_q;
          op_ready    <= 1'b1;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  regfile_core #(.DW(DW), .AW(AW)) u_core (
    .clk         (clk),
    .resetn      (resetn),
    .host_wen    (wen),
    .host_waddr  (waddr),
    .host_wdata  (wdata),
    .eng_wen     (eng_wen),
    .eng_waddr   (rd_q),
    .eng_wdata   (sum_q),
    .raddr1      (raddr1),
    .rdata1      (rdata1),
    .raddr2      (raddr2),
    .rdata2      (rdata2),
    .test_addr   (test_addr),
    .test_data   (test_data),
    .eng_raddr_a (rs1_q),
    .eng_rdata_a (eng_rdata_a),
    .eng_raddr_b (rs2_q),
    .eng_rdata_b (eng_rdata_b),
    .wr_conflict (wr_conflict)
  );

endmodule

// File: tb/tb_regfile_add_engine.sv
// Directed self-checking bench for regfile_add_engine (default or ZERO_REG_EN build).
module tb_regfile_add_engine;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          resetn;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] raddr1, raddr2, test_addr;
  logic [DW-1:0] rdata1, rdata2, test_data;
  logic          op_valid, op_ready;
  logic [AW-1:0] op_rs1, op_rs2, op_rd;
  logic          op_cin;
  logic          done_valid;
  logic [DW-1:0] done_result;
  logic          done_cout, done_ovf;
  logic          wr_conflict;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_add_engine #(.DW(DW), .AW(AW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .wen         (wen),
    .waddr       (waddr),
    .wdata       (wdata),
    .raddr1      (raddr1),
    .rdata1      (rdata1),
    .raddr2      (raddr2),
    .rdata2      (rdata2),
    .test_addr   (test_addr),
    .test_data   (test_data),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_rs1      (op_rs1),
    .op_rs2      (op_rs2),
    .op_rd       (op_rd),
    .op_cin      (op_cin),
    .done_valid  (done_valid),
    .done_result (done_result),
    .done_cout   (done_cout),
    .done_ovf    (done_ovf),
    .wr_conflict (wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wen = 1'b1; waddr = a; wdata = d;
    tick;
    wen = 1'b0;
  endtask

  task automatic peek(input logic [AW-1:0] a, output logic [DW-1:0] d);
    test_addr = a;
    #1;
    d = test_data;
  endtask

  // wr_phase: 0 none, 1 host write during READ, 3 host write during WB
  task automatic run_op(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic [AW-1:0] rd, input logic cin, input int wr_phase,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    check_val("op_ready_idle", {63'd0, op_ready}, 64'd1);
    op_valid = 1'b1; op_rs1 = rs1; op_rs2 = rs2; op_rd = rd; op_cin = cin;
    tick;
    op_valid = 1'b0;
    check_val("op_ready_busy", {63'd0, op_ready}, 64'd0);
    if (wr_phase == 1) host_write(wa, wd);
    else tick;
    tick;
    check_val("done_early", {63'd0, done_valid}, 64'd0);
    if (wr_phase == 3) host_write(wa, wd);
    else tick;
    check_val("done_pulse", {63'd0, done_valid}, 64'd1);
    check_val("op_ready_back", {63'd0, op_ready}, 64'd1);
    check_val("wr_conflict_wb", {63'd0, wr_conflict}, (wr_phase == 3) ? 64'd1 : 64'd0);
    tick;
    check_val("done_one_cycle", {63'd0, done_valid}, 64'd0);
    check_val("wr_conflict_clr", {63'd0, wr_conflict}, 64'd0);
  endtask

  initial begin
    logic [DW-1:0] d;
    int accepts;
    logic [9:0] accept_mask;

    resetn = 1'b0; wen = 1'b0; waddr = '0; wdata = '0;
    raddr1 = '0; raddr2 = '0; test_addr = '0;
    op_valid = 1'b0; op_rs1 = '0; op_rs2 = '0; op_rd = '0; op_cin = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    tick;
    check_val("rst_op_ready", {63'd0, op_ready}, 64'd1);
    check_val("rst_done_valid", {63'd0, done_valid}, 64'd0);
    check_val("rst_done_result", {32'd0, done_result}, 64'd0);

    // Reset mid-command aborts it and clears the array
    host_write(5'd5, 32'h1234_5678);
    host_write(5'd9, 32'h0000_0001);
    op_valid = 1'b1; op_rs1 = 5'd5; op_rs2 = 5'd9; op_rd = 5'd10; op_cin = 1'b0;
    tick;
    op_valid = 1'b0;
    tick;
    resetn = 1'b0;
    #2;
    check_val("midrst_op_ready", {63'd0, op_ready}, 64'd1);
    check_val("midrst_done", {63'd0, done_valid}, 64'd0);
    tick;
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      check_val("midrst_no_done", {63'd0, done_valid}, 64'd0);
    end
    for (int i = 0; i < 32; i++) begin
      peek(AW'(i), d);
      check_val($sformatf("midrst_r%0d", i), {32'd0, d}, 64'd0);
    end

    // Basic add with latency check
    host_write(5'd1, 32'h0000_0005);
    host_write(5'd2, 32'h0000_0007);
    check_val("host_wr_no_conflict", {63'd0, wr_conflict}, 64'd0);
    raddr1 = 5'd1; raddr2 = 5'd2; #1;
    check_val("rdata1_r1", {32'd0, rdata1}, 64'h5);
    check_val("rdata2_r2", {32'd0, rdata2}, 64'h7);
    run_op(5'd1, 5'd2, 5'd3, 1'b0, 0, '0, '0);
    peek(5'd3, d);
    check_val("add_r3", {32'd0, d}, 64'hC);
    check_val("add_result", {32'd0, done_result}, 64'hC);
    check_val("add_cout", {63'd0, done_cout}, 64'd0);
    check_val("add_ovf", {63'd0, done_ovf}, 64'd0);

    // Carry out with carry in
    host_write(5'd1, 32'hFFFF_FFFF);
    host_write(5'd2, 32'h0000_0001);
    run_op(5'd1, 5'd2, 5'd4, 1'b1, 0, '0, '0);
    peek(5'd4, d);
    check_val("carry_r4", {32'd0, d}, 64'h1);
    check_val("carry_cout", {63'd0, done_cout}, 64'd1);
    check_val("carry_ovf", {63'd0, done_ovf}, 64'd0);

    // Signed overflow
    host_write(5'd1, 32'h7FFF_FFFF);
    host_write(5'd2, 32'h7FFF_FFFF);
    run_op(5'd1, 5'd2, 5'd4, 1'b0, 0, '0, '0);
    peek(5'd4, d);
    check_val("ovf_r4", {32'd0, d}, 64'hFFFF_FFFE);
    check_val("ovf_cout", {63'd0, done_cout}, 64'd0);
    check_val("ovf_ovf", {63'd0, done_ovf}, 64'd1);

    // Host write dropped on the writeback edge
    host_write(5'd6, 32'h0000_0066);
    run_op(5'd1, 5'd2, 5'd3, 1'b0, 3, 5'd6, 32'hDEAD_BEEF);
    peek(5'd3, d);
    check_val("conf_r3", {32'd0, d}, 64'hFFFF_FFFE);
    peek(5'd6, d);
    check_val("conf_r6", {32'd0, d}, 64'h66);

    // Host write to rs1 on the operand-sampling edge: old value used
    host_write(5'd1, 32'h0000_0005);
    host_write(5'd2, 32'h0000_0007);
    run_op(5'd1, 5'd2, 5'd11, 1'b0, 1, 5'd1, 32'h0000_0100);
    check_val("nobypass_result", {32'd0, done_result}, 64'hC);
    peek(5'd1, d);
    check_val("nobypass_r1", {32'd0, d}, 64'h100);

    // rs1 == rs2 == rd doubling
    host_write(5'd7, 32'h0000_0010);
    run_op(5'd7, 5'd7, 5'd7, 1'b0, 0, '0, '0);
    peek(5'd7, d);
    check_val("double_r7", {32'd0, d}, 64'h20);

    // op_valid held high for 10 cycles
    host_write(5'd1, 32'h7FFF_FFFF);
    host_write(5'd2, 32'h7FFF_FFFF);
    accepts = 0; accept_mask = '0;
    op_valid = 1'b1; op_rs1 = 5'd1; op_rs2 = 5'd2; op_rd = 5'd8; op_cin = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (op_ready) begin
        accepts++;
        accept_mask[i] = 1'b1;
      end
      tick;
    end
    op_valid = 1'b0;
    repeat (4) tick;
    check_val("held_accepts", 64'(accepts), 64'd3);
    check_val("held_mask", {54'd0, accept_mask}, 64'h111);
    peek(5'd8, d);
    check_val("held_r8", {32'd0, d}, 64'hFFFF_FFFE);

    // Destination register 0
    host_write(5'd1, 32'h0000_0004);
    host_write(5'd2, 32'h0000_0005);
    run_op(5'd1, 5'd2, 5'd0, 1'b0, 0, '0, '0);
    check_val("r0_done_result", {32'd0, done_result}, 64'h9);
    raddr1 = 5'd0; raddr2 = 5'd0;
    peek(5'd0, d);
`ifdef ZERO_REG_EN
    check_val("r0_test", {32'd0, d}, 64'h0);
    check_val("r0_rdata1", {32'd0, rdata1}, 64'h0);
    check_val("r0_rdata2", {32'd0, rdata2}, 64'h0);
    host_write(5'd0, 32'hABCD_0000);
    check_val("r0_host_no_conflict", {63'd0, wr_conflict}, 64'd0);
    peek(5'd0, d);
    check_val("r0_host_wr", {32'd0, d}, 64'h0);
`else
    check_val("r0_test", {32'd0, d}, 64'h9);
    check_val("r0_rdata1", {32'd0, rdata1}, 64'h9);
    check_val("r0_rdata2", {32'd0, rdata2}, 64'h9);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
